// File: rtl/argon_alu_if.sv
// Request/result bundle for argon_alu.
//   i_valid  : request strobe; operands and opcode are sampled while high
//   i_op1    : operand A (rs1)
//   i_op2    : operand B (rs2 or immediate)
//   i_alu_op : 4-bit operation select
//   o_valid  : high the cycle after each accepted request
//   o_result : registered result
//   o_zero   : high when o_result is zero
// master = requester (execute-stage control), slave = the ALU.
interface argon_alu_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_valid;
    logic [XLEN-1:0] i_op1;
    logic [XLEN-1:0] i_op2;
    logic [3:0]      i_alu_op;
    logic            o_valid;
    logic [XLEN-1:0] o_result;
    logic            o_zero;

    modport master (
        output i_valid, i_op1, i_op2, i_alu_op,
        input  o_valid, o_result, o_zero
    );

    modport slave (
        input  i_valid, i_op1, i_op2, i_alu_op,
        output o_valid, o_result, o_zero
    );
endinterface

// File: rtl/argon_alu.sv
// Registered RV32I integer ALU for the Argon execute stage.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : argon_alu_if slave (request in, registered result out)
// One-cycle latency, one request per cycle, no backpressure.
module argon_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    argon_alu_if.slave   bus
);
    localparam int unsigned SHW = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111,
        OP_SUB  = 4'b1000,
        OP_SRA  = 4'b1010
    } alu_op_e;

    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] result_q;
    logic            valid_q;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign op1   = bus.i_op1;
    assign op2   = bus.i_op2;
    // Only the low five bits of op2 set the shift distance.
    assign shamt = op2[SHW-1:0];

    // Result mux; unused encodings fall through to zero.
    always_comb begin
        result_d = '0;
        case (alu_op_e'(bus.i_alu_op))
            OP_ADD:  result_d = op1 + op2;
            OP_SUB:  result_d = op1 - op2;
            OP_SLL:  result_d = op1 << shamt;
            OP_SLT:  result_d = {(XLEN-1)'(0), $signed(op1) < $signed(op2)};
            OP_SLTU: result_d = {(XLEN-1)'(0), op1 < op2};
            OP_XOR:  result_d = op1 ^ op2;
            OP_SRL:  result_d = op1 >> shamt;
            OP_SRA:  result_d = XLEN'($signed(op1) >>> shamt);
            OP_OR:   result_d = op1 | op2;
            OP_AND:  result_d = op1 & op2;
            default: result_d = '0;
        endcase
    end

    // Output register; result holds while idle, reset wins over a request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                result_q <= result_d;
            end
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_zero   = (result_q == '0);
endmodule

// File: tb/tb_argon_alu.sv
// Directed self-checking bench for argon_alu.
module tb_argon_alu;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    argon_alu_if #(.XLEN(32)) bus ();

    argon_alu #(.XLEN(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Check result, valid and zero together.
    task automatic chk_out(input string tag, input logic [31:0] r, input logic v);
        chk({tag, ".result"}, bus.o_result, r);
        chk({tag, ".valid"}, {31'd0, bus.o_valid}, {31'd0, v});
        chk({tag, ".zero"}, {31'd0, bus.o_zero}, {31'd0, (r == 32'd0)});
    endtask

    // Present one request and advance to just after the capturing edge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_valid  = 1'b1;
        bus.i_alu_op = op;
        bus.i_op1    = a;
        bus.i_op2    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid  = 1'b0;
        bus.i_alu_op = 4'b0000;
        bus.i_op1    = 32'h1234_5678;
        bus.i_op2    = 32'h1111_1111;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_alu_op = 4'b0000;
        bus.i_op1    = 32'd0;
        bus.i_op2    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 32'd0, 1'b0);
        rst = 1'b0;

        // Arithmetic
        do_op(4'b0000, 32'd10, 32'd5);            chk_out("add_10_5", 32'd15, 1'b1);
        do_op(4'b1000, 32'd10, 32'd5);            chk_out("sub_10_5", 32'd5, 1'b1);
        do_op(4'b1000, 32'd5, 32'd10);            chk_out("sub_5_10", 32'hFFFF_FFFB, 1'b1);

        // Shifts
        do_op(4'b0001, 32'd2, 32'd3);             chk_out("sll_2_3", 32'd16, 1'b1);
        do_op(4'b0101, 32'd16, 32'd3);            chk_out("srl_16_3", 32'd2, 1'b1);
        do_op(4'b1010, 32'hFFFF_FFF0, 32'd2);     chk_out("sra_neg", 32'hFFFF_FFFC, 1'b1);
        do_op(4'b0101, 32'hFFFF_FFF0, 32'd2);     chk_out("srl_neg", 32'h3FFF_FFFC, 1'b1);
        do_op(4'b0001, 32'd1, 32'h21);            chk_out("sll_shamt_mask", 32'd2, 1'b1);
        do_op(4'b1010, 32'h8000_0000, 32'd31);    chk_out("sra_31", 32'hFFFF_FFFF, 1'b1);

        // Compares
        do_op(4'b0010, 32'd5, 32'd10);            chk_out("slt_5_10", 32'd1, 1'b1);
        do_op(4'b0011, 32'd5, 32'd10);            chk_out("sltu_5_10", 32'd1, 1'b1);
        do_op(4'b0010, 32'hFFFF_FFFF, 32'd1);     chk_out("slt_m1_1", 32'd1, 1'b1);
        do_op(4'b0011, 32'hFFFF_FFFF, 32'd1);     chk_out("sltu_max_1", 32'd0, 1'b1);
        do_op(4'b0010, 32'd10, 32'd5);            chk_out("slt_10_5", 32'd0, 1'b1);

        // Logic and unused opcode
        do_op(4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0F0F); chk_out("xor", 32'hFFFF_FFFF, 1'b1);
        do_op(4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F0F); chk_out("or", 32'hFFFF_FFFF, 1'b1);
        do_op(4'b0111, 32'hF0F0_F0F0, 32'h0F0F_0F0F); chk_out("and", 32'h0000_0000, 1'b1);
        do_op(4'b0100, 32'hA5A5_0000, 32'h0000_5A5A); chk_out("xor2", 32'hA5A5_5A5A, 1'b1);
        do_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF); chk_out("unused_f", 32'd0, 1'b1);
        do_op(4'b0000, 32'd7, 32'd0);                 chk_out("add_7", 32'd7, 1'b1);
        do_op(4'b1001, 32'd7, 32'd3);                 chk_out("unused_9", 32'd0, 1'b1);

        // Back-to-back then idle hold
        do_op(4'b0000, 32'd100, 32'd23);          chk_out("b2b_add", 32'd123, 1'b1);
        do_op(4'b1000, 32'd100, 32'd23);          chk_out("b2b_sub", 32'd77, 1'b1);
        do_op(4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0); chk_out("b2b_and", 32'h0F00_0F00, 1'b1);
        idle();                                   chk_out("idle_hold1", 32'h0F00_0F00, 1'b0);
        idle();                                   chk_out("idle_hold2", 32'h0F00_0F00, 1'b0);

        // Reset overrides a simultaneous request
        rst = 1'b1;
        do_op(4'b0000, 32'd1, 32'd1);             chk_out("rst_over_valid", 32'd0, 1'b0);
        rst = 1'b0;
        do_op(4'b0000, 32'hFFFF_FFFF, 32'd1);     chk_out("add_wrap", 32'd0, 1'b1);
        do_op(4'b1000, 32'd0, 32'd1);             chk_out("sub_wrap", 32'hFFFF_FFFF, 1'b1);
        idle();                                   chk_out("final_idle", 32'hFFFF_FFFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
